ram_dma: RTL

Command-driven initiator that owns the single port of the 64x8 `RAM` block and performs block fill, block copy and 8-bit checksum operations on it. It sits between a controlling sequencer (for example a redstone CPU control unit) and the RAM. It drives `ADDR`/`DATA`/`WE` and consumes `Q` under the RAM's registered-address read timing: `Q` reflects the address presented one cycle earlier.

---
 rtl/ram_dma.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ram_dma.sv
// ram_dma: command-driven initiator for a 64x8 single-port RAM with a
// registered read address. It performs block fill, forward block copy and
// 8-bit additive checksum. Addresses wrap modulo the RAM depth.
module ram_dma #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic [1:0]    OP,
    input  logic [AW-1:0] SRC,
    input  logic [AW-1:0] DST,
    input  logic [AW:0]   LEN,
    input  logic [DW-1:0] FILL,
    output logic          BUSY,
    output logic          DONE,
    output logic [DW-1:0] SUM,
    output logic [AW-1:0] M_ADDR,
    output logic [DW-1:0] M_DATA,
    output logic          M_WE,
    input  logic [DW-1:0] M_Q
);

    localparam logic [1:0]    OP_FILL = 2'b00;
    localparam logic [1:0]    OP_COPY = 2'b01;
    localparam logic [1:0]    OP_SUM  = 2'b10;
    localparam logic [1:0]    OP_NOP  = 2'b11;
    localparam logic [AW:0]   MAX_LEN = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   ZERO_C  = {(AW+1){1'b0}};
    localparam logic [AW:0]   ONE_C   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ZERO_A  = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_A   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] ZERO_D  = {DW{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILL     = 3'd1,
        S_CPY_RD   = 3'd2,
        S_CPY_WR   = 3'd3,
        S_SUM_RD   = 3'd4,
        S_SUM_LAST = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t        state_r, state_s;
    logic [AW:0]   cnt_r, cnt_s;       // bytes still to move after the current one
    logic [AW-1:0] src_r, src_s;       // next source address
    logic [AW-1:0] dst_r, dst_s;       // next destination address
    logic [DW-1:0] fill_r, fill_s;
    logic [DW-1:0] sum_r, sum_s;
    logic [AW-1:0] addr_r, addr_s;
    logic          we_r, we_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          rd_pend_r;          // a checksum read was presented last cycle
    logic [AW:0]   len_clamp_s;

    // Clamp the requested length to the RAM depth.
    always_comb begin
        if (LEN > MAX_LEN) begin
            len_clamp_s = MAX_LEN;
        end else begin
            len_clamp_s = LEN;
        end
    end

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        src_s   = src_r;
        dst_s   = dst_r;
        fill_s  = fill_r;
        addr_s  = addr_r;
        we_s    = 1'b0;
        busy_s  = busy_r;
        done_s  = 1'b0;
        // RAM data for the read presented last cycle is on M_Q now.
        if (rd_pend_r) begin
            sum_s = sum_r + M_Q;
        end else begin
            sum_s = sum_r;
        end

        case (state_r)
            S_IDLE: begin
                busy_s = 1'b0;
                if (START) begin
                    fill_s = FILL;
                    src_s  = SRC;
                    dst_s  = DST;
                    cnt_s  = len_clamp_s - ONE_C;
                    if (OP == OP_SUM) begin
                        sum_s = ZERO_D;
                    end else begin
                        sum_s = sum_r;
                    end
                    if ((len_clamp_s == ZERO_C) || (OP == OP_NOP)) begin
                        state_s = S_DONE;
                        done_s  = 1'b1;
                    end else begin
                        case (OP)
                            OP_FILL: begin
                                state_s = S_FILL;
                                addr_s  = DST;
                                we_s    = 1'b1;
                                busy_s  = 1'b1;
                                dst_s   = DST + ONE_A;
                            end
                            OP_COPY: begin
                                state_s = S_CPY_RD;
                                addr_s  = SRC;
                                busy_s  = 1'b1;
                                src_s   = SRC + ONE_A;
                            end
                            OP_SUM: begin
                                state_s = S_SUM_RD;
                                addr_s  = SRC;
                                busy_s  = 1'b1;
                                src_s   = SRC + ONE_A;
                            end
                            default: begin
                                state_s = S_DONE;
                                done_s  = 1'b1;
                            end
                        endcase
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FILL: begin
                if (cnt_r == ZERO_C) begin
                    state_s = S_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    addr_s = dst_r;
                    we_s   = 1'b1;
                    dst_s  = dst_r + ONE_A;
                    cnt_s  = cnt_r - ONE_C;
                end
            end
            S_CPY_RD: begin
                state_s = S_CPY_WR;
                addr_s  = dst_r;
                we_s    = 1'b1;
                dst_s   = dst_r + ONE_A;
            end
            S_CPY_WR: begin
                if (cnt_r == ZERO_C) begin
                    state_s = S_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = S_CPY_RD;
                    addr_s  = src_r;
                    src_s   = src_r + ONE_A;
                    cnt_s   = cnt_r - ONE_C;
                end
            end
            S_SUM_RD: begin
                if (cnt_r == ZERO_C) begin
                    state_s = S_SUM_LAST;
                end else begin
                    addr_s = src_r;
                    src_s  = src_r + ONE_A;
                    cnt_s  = cnt_r - ONE_C;
                end
            end
            S_SUM_LAST: begin
                state_s = S_DONE;
                busy_s  = 1'b0;
                done_s  = 1'b1;
            end
            S_DONE: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r   <= S_IDLE;
            cnt_r     <= ZERO_C;
            src_r     <= ZERO_A;
            dst_r     <= ZERO_A;
            fill_r    <= ZERO_D;
            sum_r     <= ZERO_D;
            addr_r    <= ZERO_A;
            we_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rd_pend_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            src_r     <= src_s;
            dst_r     <= dst_s;
            fill_r    <= fill_s;
            sum_r     <= sum_s;
            addr_r    <= addr_s;
            we_r      <= we_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            rd_pend_r <= (state_r == S_SUM_RD);
        end
    end

    // Write data: copy writes forward the RAM read data, all else drives fill value.
    always_comb begin
        if (state_r == S_CPY_WR) begin
            M_DATA = M_Q;
        end else begin
            M_DATA = fill_r;
        end
    end

    assign BUSY   = busy_r;
    assign DONE   = done_r;
    assign SUM    = sum_r;
    assign M_ADDR = addr_r;
    assign M_WE   = we_r;

endmodule
